// File: rtl/enc_pkg.sv
// Shared types and constants for the serial 8-to-3 encoder.
// Holds the FSM state enum and the popcount used for merge accounting.
package enc_pkg;

    localparam int ENC_W     = 3;
    localparam int REQ_W     = 8;
    localparam int MERGE_MAX = 255;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    function automatic logic [3:0] popcount8(input logic [REQ_W-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < REQ_W; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder.
// PRIO_HIGH=1 lets bit 7 win; PRIO_HIGH=0 lets bit 0 win.
module prio_enc8
    import enc_pkg::*;
#(
    parameter int PRIO_HIGH = 1
) (
    input  logic [REQ_W-1:0] req,
    output logic [ENC_W-1:0] idx,
    output logic             any
);

    // The last set bit visited by the loop wins, so loop direction sets priority.
    always_comb begin
        idx = '0;
        any = |req;
        if (PRIO_HIGH != 0) begin
            for (int i = 0; i < REQ_W; i++) begin
                if (req[i]) idx = ENC_W'(i);
            end
        end else begin
            for (int i = REQ_W - 1; i >= 0; i--) begin
                if (req[i]) idx = ENC_W'(i);
            end
        end
    end

endmodule

// File: rtl/enc8to3_serial.sv
// Sequential 8-to-3 encoder: accumulates request strobes in a pending vector
// and hands out one index per valid/ready transfer in priority order.
module enc8to3_serial
    import enc_pkg::*;
#(
    parameter int PRIO_HIGH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_W-1:0] in,
    input  logic             en,
    output logic [ENC_W-1:0] out,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [REQ_W-1:0] pend,
    output logic [7:0]       merge_cnt
);

    state_t           state, state_nxt;
    logic [ENC_W-1:0] sel_idx, out_nxt;
    logic             sel_any, out_vld_nxt, load;
    logic [REQ_W-1:0] load_mask, held_mask, req, merged, pend_nxt;
    logic [8:0]       merge_sum;
    logic [7:0]       merge_nxt;

    prio_enc8 #(
        .PRIO_HIGH(PRIO_HIGH)
    ) u_prio (
        .req(pend),
        .idx(sel_idx),
        .any(sel_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_vld   <= 1'b0;
            pend      <= '0;
            merge_cnt <= '0;
        end else begin
            state     <= state_nxt;
            out       <= out_nxt;
            out_vld   <= out_vld_nxt;
            pend      <= pend_nxt;
            merge_cnt <= merge_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        out_nxt     = out;
        out_vld_nxt = out_vld;
        load        = 1'b0;
        case (state)
            IDLE: begin
                out_vld_nxt = 1'b0;
                if (sel_any) begin
                    load        = 1'b1;
                    out_nxt     = sel_idx;
                    out_vld_nxt = 1'b1;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (out_rdy) begin
                    if (sel_any) begin
                        load    = 1'b1;
                        out_nxt = sel_idx;
                    end else begin
                        out_vld_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end
                end
            end
            default: begin
                out_vld_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    // A re-request of the bit being loaded re-arms it (set wins) and is not a merge;
    // a re-request of the presented index is absorbed as a merge.
    always_comb begin
        load_mask = load ? (REQ_W'(1) << sel_idx) : '0;
        held_mask = out_vld ? (REQ_W'(1) << out) : '0;
        req       = en ? in : '0;
        merged    = req & ((pend & ~load_mask) | held_mask);
        pend_nxt  = (pend & ~load_mask) | (req & ~held_mask);
        merge_sum = {1'b0, merge_cnt} + 9'(popcount8(merged));
        merge_nxt = (merge_sum > 9'(MERGE_MAX)) ? 8'(MERGE_MAX) : merge_sum[7:0];
    end

endmodule

// File: tb/tb_enc8to3_serial.sv
// Scoreboard bench for enc8to3_serial: one instance per priority direction,
// expected indices queued at stimulus time and popped on each transfer.
module tb_enc8to3_serial;

    logic       clk, rst, en, out_rdy;
    logic [7:0] in_req;
    logic [2:0] out_hi, out_lo;
    logic       vld_hi, vld_lo;
    logic [7:0] pend_hi, pend_lo, mcnt_hi, mcnt_lo;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb_hi[$];
    logic [7:0] sb_lo[$];

    enc8to3_serial #(.PRIO_HIGH(1)) dut_hi (
        .clk(clk), .rst(rst), .in(in_req), .en(en),
        .out(out_hi), .out_vld(vld_hi), .out_rdy(out_rdy),
        .pend(pend_hi), .merge_cnt(mcnt_hi)
    );

    enc8to3_serial #(.PRIO_HIGH(0)) dut_lo (
        .clk(clk), .rst(rst), .in(in_req), .en(en),
        .out(out_lo), .out_vld(vld_lo), .out_rdy(out_rdy),
        .pend(pend_lo), .merge_cnt(mcnt_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] v);
        in_req = v;
        en     = 1'b1;
        @(negedge clk);
        in_req = '0;
        en     = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drainCheck(input string tag);
        checkOutput({tag, "_hi_q_empty"}, 8'(sb_hi.size()), 8'd0);
        checkOutput({tag, "_lo_q_empty"}, 8'(sb_lo.size()), 8'd0);
        checkOutput({tag, "_hi_vld_low"}, {7'b0, vld_hi}, 8'd0);
        checkOutput({tag, "_lo_vld_low"}, {7'b0, vld_lo}, 8'd0);
    endtask

    // Transfers are sampled after the bench has settled out_rdy for the next edge.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_rdy && vld_hi) begin
            if (sb_hi.size() == 0) checkOutput("hi_spurious", {7'b0, vld_hi}, 8'd0);
            else checkOutput("hi_order", {5'b0, out_hi}, sb_hi.pop_front());
        end
        if (!rst && out_rdy && vld_lo) begin
            if (sb_lo.size() == 0) checkOutput("lo_spurious", {7'b0, vld_lo}, 8'd0);
            else checkOutput("lo_order", {5'b0, out_lo}, sb_lo.pop_front());
        end
    end

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        in_req  = '0;
        out_rdy = 1'b0;
        waitCycles(2);
        checkOutput("rst_out", {5'b0, out_hi}, 8'd0);
        checkOutput("rst_vld", {7'b0, vld_hi}, 8'd0);
        checkOutput("rst_pend", pend_hi, 8'h00);
        checkOutput("rst_mcnt", mcnt_hi, 8'd0);
        rst = 1'b0;
        waitCycles(1);

        // Single request: valid for exactly one cycle, two cycles after the strobe
        $display("[TB] single request");
        out_rdy = 1'b1;
        sb_hi.push_back(8'd3);
        sb_lo.push_back(8'd3);
        applyStimulus(8'b0000_1000);
        checkOutput("single_vld_early", {7'b0, vld_hi}, 8'd0);
        checkOutput("single_pend", pend_hi, 8'h08);
        waitCycles(1);
        checkOutput("single_vld", {7'b0, vld_hi}, 8'd1);
        checkOutput("single_out", {5'b0, out_hi}, 8'd3);
        checkOutput("single_pend_clr", pend_hi, 8'h00);
        waitCycles(1);
        checkOutput("single_vld_one", {7'b0, vld_hi}, 8'd0);
        drainCheck("single");

        // Multi-hot burst, back-to-back transfers
        $display("[TB] burst");
        sb_hi.push_back(8'd7); sb_hi.push_back(8'd2); sb_hi.push_back(8'd0);
        sb_lo.push_back(8'd0); sb_lo.push_back(8'd2); sb_lo.push_back(8'd7);
        applyStimulus(8'b1000_0101);
        for (int i = 0; i < 3; i++) begin
            waitCycles(1);
            checkOutput("burst_vld_hi", {7'b0, vld_hi}, 8'd1);
            checkOutput("burst_vld_lo", {7'b0, vld_lo}, 8'd1);
        end
        waitCycles(2);
        drainCheck("burst");

        // Stall with index 2 presented, new arrival for 7
        $display("[TB] stall");
        out_rdy = 1'b0;
        sb_hi.push_back(8'd2); sb_lo.push_back(8'd2);
        applyStimulus(8'b0000_0100);
        waitCycles(1);
        checkOutput("stall_out0", {5'b0, out_hi}, 8'd2);
        sb_hi.push_back(8'd7); sb_lo.push_back(8'd7);
        applyStimulus(8'b1000_0000);
        checkOutput("stall_out_hi", {5'b0, out_hi}, 8'd2);
        checkOutput("stall_out_lo", {5'b0, out_lo}, 8'd2);
        checkOutput("stall_pend_hi", pend_hi, 8'h80);
        checkOutput("stall_pend_lo", pend_lo, 8'h80);
        out_rdy = 1'b1;
        waitCycles(1);
        checkOutput("stall_next_out", {5'b0, out_hi}, 8'd7);
        checkOutput("stall_next_vld", {7'b0, vld_hi}, 8'd1);
        waitCycles(1);
        drainCheck("stall");

        // Enable gating
        $display("[TB] enable");
        in_req = 8'hFF;
        en     = 1'b0;
        waitCycles(1);
        in_req = '0;
        waitCycles(1);
        checkOutput("en_pend_hi", pend_hi, 8'h00);
        checkOutput("en_pend_lo", pend_lo, 8'h00);
        checkOutput("en_mcnt", mcnt_hi, 8'd0);
        drainCheck("en");

        // Merge against pending and against the presented index
        $display("[TB] merge");
        out_rdy = 1'b0;
        sb_hi.push_back(8'd2); sb_lo.push_back(8'd2);
        applyStimulus(8'b0000_0100);
        waitCycles(1);
        sb_hi.push_back(8'd3); sb_lo.push_back(8'd3);
        applyStimulus(8'b0000_1000);
        applyStimulus(8'b0000_1000);
        checkOutput("merge_pend_mcnt", mcnt_hi, 8'd1);
        checkOutput("merge_pend_vec", pend_hi, 8'h08);
        applyStimulus(8'b0000_0100);
        checkOutput("merge_held_mcnt", mcnt_lo, 8'd2);
        checkOutput("merge_held_pend", pend_lo, 8'h08);
        out_rdy = 1'b1;
        waitCycles(3);
        checkOutput("merge_mcnt_keep", mcnt_hi, 8'd2);
        drainCheck("merge");

        // Re-request of the bit being loaded re-arms it without counting a merge
        $display("[TB] set wins");
        sb_hi.push_back(8'd3); sb_hi.push_back(8'd3);
        sb_lo.push_back(8'd3); sb_lo.push_back(8'd3);
        applyStimulus(8'b0000_1000);
        applyStimulus(8'b0000_1000);
        checkOutput("setwin_out", {5'b0, out_hi}, 8'd3);
        checkOutput("setwin_pend", pend_hi, 8'h08);
        checkOutput("setwin_mcnt", mcnt_hi, 8'd2);
        waitCycles(3);
        checkOutput("setwin_pend_clr", pend_hi, 8'h00);
        drainCheck("setwin");

        // Saturation of the merge counter
        $display("[TB] saturation");
        out_rdy = 1'b0;
        sb_hi.push_back(8'd4); sb_lo.push_back(8'd4);
        applyStimulus(8'b0001_0000);
        waitCycles(1);
        in_req = 8'b0001_0000;
        en     = 1'b1;
        waitCycles(100);
        checkOutput("sat_mid", mcnt_hi, 8'd102);
        waitCycles(200);
        en     = 1'b0;
        in_req = '0;
        checkOutput("sat_hi", mcnt_hi, 8'd255);
        checkOutput("sat_lo", mcnt_lo, 8'd255);
        out_rdy = 1'b1;
        waitCycles(3);
        drainCheck("sat");

        // Asynchronous reset between edges with everything pending
        $display("[TB] reset mid-operation");
        out_rdy = 1'b0;
        applyStimulus(8'hFF);
        applyStimulus(8'hFF);
        checkOutput("prerst_pend", pend_hi, 8'hFF);
        checkOutput("prerst_vld", {7'b0, vld_hi}, 8'd1);
        checkOutput("prerst_out_hi", {5'b0, out_hi}, 8'd7);
        checkOutput("prerst_out_lo", {5'b0, out_lo}, 8'd0);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_async_vld", {7'b0, vld_hi}, 8'd0);
        checkOutput("rst_async_pend", pend_hi, 8'h00);
        checkOutput("rst_async_mcnt", mcnt_hi, 8'd0);
        checkOutput("rst_async_out", {5'b0, out_hi}, 8'd0);
        rst = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitCycles(1);
            checkOutput("postrst_idle", {7'b0, vld_hi}, 8'd0);
        end

        // Multi-bit merge increment in one cycle
        $display("[TB] multi-bit merge");
        out_rdy = 1'b0;
        sb_hi.push_back(8'd0); sb_lo.push_back(8'd0);
        applyStimulus(8'b0000_0001);
        waitCycles(1);
        applyStimulus(8'h0F);
        checkOutput("pop_mcnt1", mcnt_hi, 8'd1);
        checkOutput("pop_pend", pend_hi, 8'h0E);
        applyStimulus(8'h0F);
        checkOutput("pop_mcnt5", mcnt_hi, 8'd5);
        sb_hi.push_back(8'd3); sb_hi.push_back(8'd2); sb_hi.push_back(8'd1);
        sb_lo.push_back(8'd1); sb_lo.push_back(8'd2); sb_lo.push_back(8'd3);
        out_rdy = 1'b1;
        waitCycles(6);
        drainCheck("pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
